// File: rtl/speed_round_ctrl.sv
// Speed-round sequencer for the tug-of-war game: countdown, press window,
// compare settle, winner latch and counter clear, with abort at any point.
module speed_round_ctrl #(
   parameter int unsigned TICK_CYCLES   = 50_000_000,
   parameter int unsigned COUNT_SECS    = 3,
   parameter int unsigned ROUND_CYCLES  = 250_000_000,
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   input  logic       speed_right,
   input  logic       speed_tie,
   output logic       speed_round,
   output logic       speed_exit,
   output logic [3:0] countdown,
   output logic       busy,
   output logic       done,
   output logic       result_valid,
   output logic       result_right,
   output logic       result_tie
);

   localparam int unsigned TICK_W   = $clog2(TICK_CYCLES + 1);
   localparam int unsigned ROUND_W  = $clog2(ROUND_CYCLES + 1);
   localparam int unsigned SETTLE_W = $clog2(SETTLE_CYCLES + 1);

   localparam logic [TICK_W-1:0]   TICK_LAST   = TICK_W'(TICK_CYCLES - 1);
   localparam logic [ROUND_W-1:0]  ROUND_LAST  = ROUND_W'(ROUND_CYCLES - 1);
   localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
   localparam logic [3:0]          COUNT_INIT  = 4'(COUNT_SECS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_COUNTDOWN,
      S_ROUND,
      S_SETTLE,
      S_SAMPLE,
      S_EXIT,
      S_ABORT
   } state_t;

   state_t              state;
   logic [TICK_W-1:0]   tick_cnt;
   logic [ROUND_W-1:0]  round_cnt;
   logic [SETTLE_W-1:0] settle_cnt;

   // Abort is honoured only while a round is in flight; EXIT always completes.
   logic abortable;
   assign abortable = abort && (state inside {S_COUNTDOWN, S_ROUND, S_SETTLE, S_SAMPLE});

   // NOTE: every output is a flop set on the transition into its state, so
   // all state and outputs update with non-blocking assignments in one block.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= S_IDLE;
         tick_cnt     <= '0;
         round_cnt    <= '0;
         settle_cnt   <= '0;
         speed_round  <= 1'b0;
         speed_exit   <= 1'b0;
         countdown    <= 4'd0;
         busy         <= 1'b0;
         done         <= 1'b0;
         result_valid <= 1'b0;
         result_right <= 1'b0;
         result_tie   <= 1'b0;
      end else begin
         done       <= 1'b0;
         speed_exit <= 1'b0;

         if (abortable) begin
            state        <= S_ABORT;
            speed_exit   <= 1'b1;
            speed_round  <= 1'b0;
            countdown    <= 4'd0;
            result_valid <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start && !abort) begin
                     state        <= S_COUNTDOWN;
                     busy         <= 1'b1;
                     countdown    <= COUNT_INIT;
                     tick_cnt     <= '0;
                     result_valid <= 1'b0;
                  end
               end

               S_COUNTDOWN: begin
                  if (tick_cnt == TICK_LAST) begin
                     tick_cnt <= '0;
                     if (countdown == 4'd1) begin
                        state       <= S_ROUND;
                        countdown   <= 4'd0;
                        speed_round <= 1'b1;
                        round_cnt   <= '0;
                     end else begin
                        countdown <= countdown - 4'd1;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end

               S_ROUND: begin
                  if (round_cnt == ROUND_LAST) begin
                     state       <= S_SETTLE;
                     speed_round <= 1'b0;
                     settle_cnt  <= '0;
                  end else begin
                     round_cnt <= round_cnt + 1'b1;
                  end
               end

               // Waits out the push counter's press->count->compare pipeline.
               S_SETTLE: begin
                  if (settle_cnt == SETTLE_LAST) begin
                     state <= S_SAMPLE;
                  end else begin
                     settle_cnt <= settle_cnt + 1'b1;
                  end
               end

               S_SAMPLE: begin
                  state        <= S_EXIT;
                  result_right <= speed_right;
                  result_tie   <= speed_tie;
                  speed_exit   <= 1'b1;
                  done         <= 1'b1;
                  result_valid <= 1'b1;
               end

               S_EXIT: begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end

               S_ABORT: begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end

               default: begin
                  state       <= S_IDLE;
                  busy        <= 1'b0;
                  speed_round <= 1'b0;
                  countdown   <= 4'd0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_speed_round_ctrl.sv
// Bench for speed_round_ctrl: table of rounds with a push-counter model,
// scoreboard of expected winners, plus reset and idle corner sequences.
module tb_speed_round_ctrl;

   localparam int TICK   = 4;
   localparam int SECS   = 3;
   localparam int ROUND  = 20;
   localparam int SETTLE = 2;

   // Cycle n is the clock period after edge n; start is driven in cycle 0.
   localparam int RISE    = 1 + SECS * TICK;       // first speed_round cycle
   localparam int FALL    = RISE + ROUND - 1;      // last speed_round cycle
   localparam int EXITC   = FALL + SETTLE + 2;     // speed_exit / done cycle
   localparam int RUN_LEN = EXITC + 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       speed_right, speed_tie;
   logic       speed_round, speed_exit, busy, done;
   logic       result_valid, result_right, result_tie;
   logic [3:0] countdown;

   logic       r_press = 1'b0;
   logic       l_press = 1'b0;
   logic       rp_q, lp_q;
   logic [7:0] r_cnt, l_cnt;

   int n_checks = 0;
   int n_errors = 0;
   int cur_cyc  = 0;

   typedef struct {
      int r_n;
      int l_n;
      bit last_press;
      int abort_at;
      int start_hold;
      bit exp_right;
      bit exp_tie;
   } vec_t;

   typedef struct packed {
      logic right;
      logic tie;
   } sb_t;

   vec_t vecs[12];
   sb_t  sb_q[$];

   always #5 clk = ~clk;

   speed_round_ctrl #(
      .TICK_CYCLES  (TICK),
      .COUNT_SECS   (SECS),
      .ROUND_CYCLES (ROUND),
      .SETTLE_CYCLES(SETTLE)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .abort       (abort),
      .speed_right (speed_right),
      .speed_tie   (speed_tie),
      .speed_round (speed_round),
      .speed_exit  (speed_exit),
      .countdown   (countdown),
      .busy        (busy),
      .done        (done),
      .result_valid(result_valid),
      .result_right(result_right),
      .result_tie  (result_tie)
   );

   // Push counter: registered press, registered count, registered compare.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rp_q        <= 1'b0;
         lp_q        <= 1'b0;
         r_cnt       <= 8'd0;
         l_cnt       <= 8'd0;
         speed_right <= 1'b0;
         speed_tie   <= 1'b0;
      end else begin
         rp_q <= r_press && speed_round;
         lp_q <= l_press && speed_round;
         if (speed_exit) begin
            r_cnt <= 8'd0;
            l_cnt <= 8'd0;
         end else begin
            r_cnt <= r_cnt + 8'(rp_q);
            l_cnt <= l_cnt + 8'(lp_q);
         end
         speed_right <= r_cnt > l_cnt;
         speed_tie   <= r_cnt == l_cnt;
      end
   end

   task automatic check(input string name, input int cyc, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask

   // {countdown, speed_round, speed_exit, done, busy} expected in cycle c.
   function automatic logic [7:0] exp_ctl(input int c, input int a);
      logic [3:0] cd;
      logic sr, ex, dn, bz;
      if (a >= 0 && a < EXITC && c > a) begin
         cd = 4'd0;
         sr = 1'b0;
         dn = 1'b0;
         ex = (c == a + 1);
         bz = (c == a + 1);
      end else begin
         cd = (c >= 1 && c < RISE) ? 4'(SECS - (c - 1) / TICK) : 4'd0;
         sr = (c >= RISE && c <= FALL);
         ex = (c == EXITC);
         dn = (c == EXITC);
         bz = (c >= 1 && c <= EXITC);
      end
      return {cd, sr, ex, dn, bz};
   endfunction

   function automatic logic exp_valid(input int c, input int a);
      if (a >= 0 && a < EXITC) return 1'b0;
      return c >= EXITC;
   endfunction

   // Scoreboard consumer: every done pops one expected winner.
   always @(negedge clk) begin
      if (rst && done) begin
         if (sb_q.size() == 0) begin
            check("done_unexpected", cur_cyc, 32'(done), 32'd0);
         end else begin
            sb_t e;
            e = sb_q.pop_front();
            check("result_right", cur_cyc, 32'(result_right), 32'(e.right));
            check("result_tie", cur_cyc, 32'(result_tie), 32'(e.tie));
            check("valid_at_done", cur_cyc, 32'(result_valid), 32'd1);
         end
      end
   end

   // Entered and left just after a rising edge.
   task automatic run_vec(input int idx, input vec_t v);
      bit completes;
      completes = (v.abort_at < 0) || (v.abort_at >= EXITC);
      if (completes) sb_q.push_back('{right: v.exp_right, tie: v.exp_tie});
      for (int c = 0; c < RUN_LEN; c++) begin
         cur_cyc = c;
         start   = (c < v.start_hold);
         abort   = (c == v.abort_at);
         r_press = ((c >= RISE) && (((c - RISE) % 2) == 0) && (((c - RISE) / 2) < v.r_n))
                   || (v.last_press && (c == FALL));
         l_press = (c >= RISE) && (((c - RISE) % 2) == 1) && (((c - RISE) / 2) < v.l_n);
         @(negedge clk);
         check($sformatf("ctl_v%0d", idx), c,
               32'({countdown, speed_round, speed_exit, done, busy}),
               32'(exp_ctl(c, v.abort_at)));
         if (c >= 1)
            check($sformatf("valid_v%0d", idx), c, 32'(result_valid),
                  32'(exp_valid(c, v.abort_at)));
         @(posedge clk);
         #1;
      end
      start   = 1'b0;
      abort   = 1'b0;
      r_press = 1'b0;
      l_press = 1'b0;
      check($sformatf("sb_empty_v%0d", idx), RUN_LEN, 32'(sb_q.size()), 32'd0);
      if (!completes) begin
         check($sformatf("kept_right_v%0d", idx), RUN_LEN, 32'(result_right), 32'(v.exp_right));
         check($sformatf("kept_tie_v%0d", idx), RUN_LEN, 32'(result_tie), 32'(v.exp_tie));
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cur_cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      // r_n, l_n, last_press, abort_at, start_hold, exp_right, exp_tie
      vecs[0]  = '{7, 5, 1'b0, -1, 1,  1'b1, 1'b0};
      vecs[1]  = '{4, 4, 1'b0, -1, 1,  1'b0, 1'b1};
      vecs[2]  = '{2, 6, 1'b0, -1, 1,  1'b0, 1'b0};
      vecs[3]  = '{3, 4, 1'b1, -1, 1,  1'b0, 1'b1};   // last-cycle press forces tie
      vecs[4]  = '{5, 5, 1'b1, -1, 1,  1'b1, 1'b0};   // last-cycle press wins
      vecs[5]  = '{0, 0, 1'b0, -1, 1,  1'b0, 1'b1};
      vecs[6]  = '{1, 0, 1'b0, -1, 37, 1'b1, 1'b0};   // start held across the round
      vecs[7]  = '{3, 1, 1'b0, 20, 1,  1'b1, 1'b0};   // abort in ROUND keeps old result
      vecs[8]  = '{0, 2, 1'b0, 36, 1,  1'b0, 1'b0};   // abort in EXIT ignored
      vecs[9]  = '{2, 0, 1'b0, 35, 1,  1'b0, 1'b0};   // abort in SAMPLE, no latch
      vecs[10] = '{0, 0, 1'b0, 1,  1,  1'b0, 1'b0};   // abort in first countdown cycle
      vecs[11] = '{7, 5, 1'b0, -1, 1,  1'b1, 1'b0};   // full round after reset

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_state", 0,
            32'({countdown, speed_round, speed_exit, done, busy,
                 result_valid, result_right, result_tie}), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;

      for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

      // start together with abort in IDLE never leaves IDLE
      start = 1'b1;
      abort = 1'b1;
      for (int c = 0; c < 5; c++) begin
         cur_cyc = c;
         @(negedge clk);
         check("idle_abort_busy", c, 32'(busy), 32'd0);
         check("idle_abort_countdown", c, 32'(countdown), 32'd0);
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      abort = 1'b0;

      // asynchronous reset in the middle of ROUND
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (19) @(posedge clk);
      #1;
      check("round_before_reset", 20, 32'(speed_round), 32'd1);
      #2;
      rst = 1'b0;
      #1;
      check("async_reset_outputs", 20,
            32'({countdown, speed_round, speed_exit, done, busy,
                 result_valid, result_right, result_tie}), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      run_vec(11, vecs[11]);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
